// File: rtl/fetch_stage_pkg.sv
// Shared types and defaults for the fetch stage.
// Holds FSM encoding, IF/ID bundle, XLEN and reset/NOP constants.
package fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

  function automatic if_id_t bubble(
    input logic [XLEN-1:0] nop
  );
    if_id_t b;
    b.instr    = nop;
    b.pc       = '0;
    b.pc_plus4 = '0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request bus between fetch and imem.
// master: ImemReq/ImemAddr out, ImemAck/ImemRdata in.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            ImemReq;
  logic [XLEN-1:0] ImemAddr;
  logic            ImemAck;
  logic [XLEN-1:0] ImemRdata;

  modport master (
    output ImemReq,
    output ImemAddr,
    input  ImemAck,
    input  ImemRdata
  );

  modport slave (
    input  ImemReq,
    input  ImemAddr,
    output ImemAck,
    output ImemRdata
  );

endinterface

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: flush beats stall beats load.
// Ports: clock, reset, flush, stall, load, din -> dout.
module fetch_ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   flush,
  input  logic   stall,
  input  logic   load,
  input  if_id_t din,
  output if_id_t dout
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dout <= bubble(NOP_INSTR);
    end else if (flush) begin
      dout <= bubble(NOP_INSTR);
    end else if (!stall) begin
      dout <= load ? din : bubble(NOP_INSTR);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, imem handshake FSM, hold buffer, IF/ID reg.
// Ports: clock/reset, hazard ctl, redirect, imem (master), IF/ID.
// Optional FETCH_PERF_CNT_EN adds FetchCount/StallCount outputs.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  fetch_stage_if.master   imem,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     FetchCount,
  output logic [31:0]     StallCount
`endif
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pcf;
  logic [XLEN-1:0] drop_pc;
  logic [XLEN-1:0] hold_instr;
  logic [XLEN-1:0] hold_pc;
  logic            hold_vld;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic            take;
  logic            capture;
  logic            give;
  logic            word_vld;
  logic [XLEN-1:0] word_pc;
  if_id_t          word;
  if_id_t          ifid_q;

  assign ack           = imem.ImemAck;
  assign imem.ImemReq  = req;
  assign imem.ImemAddr = addr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_START;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_START: state_nxt = S_FETCH;
      S_FETCH: begin
        if (PCSrcE)
          state_nxt = ack ? S_FETCH : S_DROP;
        else if (ack && StallF)
          state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (PCSrcE || give)
          state_nxt = S_FETCH;
      end
      S_DROP: begin
        if (ack) state_nxt = S_FETCH;
      end
      default: state_nxt = S_START;
    endcase
  end

  // In S_DROP the bus keeps the abandoned address while
  // pcf already points at the redirect target.
  always_comb begin
    req      = (state == S_FETCH) || (state == S_DROP);
    addr     = (state == S_DROP) ? drop_pc : pcf;
    take     = (state == S_FETCH) && ack && !PCSrcE
               && !StallF;
    capture  = (state == S_FETCH) && ack && !PCSrcE
               && StallF;
    give     = (state == S_HOLD) && hold_vld && !PCSrcE
               && !StallF && !StallD;
    word_vld = take || give;
    word_pc  = give ? hold_pc : pcf;
    word.instr    = give ? hold_instr : imem.ImemRdata;
    word.pc       = word_pc;
    word.pc_plus4 = word_pc + 32'd4;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pcf        <= RESET_PC;
      drop_pc    <= RESET_PC;
      hold_instr <= '0;
      hold_pc    <= '0;
      hold_vld   <= 1'b0;
    end else begin
      if (PCSrcE)        pcf <= PCTargetE;
      else if (word_vld) pcf <= pcf + 32'd4;
      if ((state == S_FETCH) && PCSrcE && !ack)
        drop_pc <= pcf;
      if (capture) begin
        hold_instr <= imem.ImemRdata;
        hold_pc    <= pcf;
        hold_vld   <= 1'b1;
      end else if (PCSrcE || give) begin
        hold_vld   <= 1'b0;
      end
    end
  end

  fetch_ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid (
    .clock(clock),
    .reset(reset),
    .flush(FlushD),
    .stall(StallD),
    .load (word_vld),
    .din  (word),
    .dout (ifid_q)
  );

  assign InstrD   = ifid_q.instr;
  assign PCD      = ifid_q.pc;
  assign PCPlus4D = ifid_q.pc_plus4;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      FetchCount <= '0;
      StallCount <= '0;
    end else begin
      if (word_vld && !FlushD && !StallD)
        FetchCount <= FetchCount + 32'd1;
      if (((state == S_FETCH) && !ack) || (state == S_HOLD))
        StallCount <= StallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised bench for fetch_stage against a transaction model.
// Directed opening sequence, then random hazards/redirects/resets.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        StallF = 1'b0;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        ack_r = 1'b0;
  logic [31:0] InstrD, PCD, PCPlus4D;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCount, StallCount;
`endif

  fetch_stage_if imem();

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem.ImemAck   = ack_r;
  assign imem.ImemRdata = mem_word(imem.ImemAddr);

  fetch_stage dut (
    .clock    (clock),
    .reset    (reset),
    .StallF   (StallF),
    .StallD   (StallD),
    .FlushD   (FlushD),
    .PCSrcE   (PCSrcE),
    .PCTargetE(PCTargetE),
    .imem     (imem),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCount(FetchCount),
    .StallCount(StallCount)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  // Model: the stage is either booting, fetching, holding
  // a stalled word, or waiting out an abandoned request.
  bit          m_boot, m_hold, m_drop;
  logic [31:0] m_pc, m_drop_addr, m_hw, m_hpc;
  logic [31:0] m_instr, m_pcd, m_pc4;
  logic [31:0] m_fc, m_sc;

  task automatic model_reset();
    m_boot  = 1; m_hold = 0; m_drop = 0;
    m_pc    = 32'h0; m_drop_addr = 32'h0;
    m_hw    = 0; m_hpc = 0;
    m_instr = NOP; m_pcd = 0; m_pc4 = 0;
    m_fc    = 0; m_sc = 0;
  endtask

  task automatic check_outputs();
    logic        req;
    logic [31:0] addr;
    req  = !m_boot && !m_hold;
    addr = m_drop ? m_drop_addr : m_pc;
    check("req", {31'b0, imem.ImemReq}, {31'b0, req});
    check("addr", imem.ImemAddr, addr);
    check("instr", InstrD, m_instr);
    check("pcd", PCD, m_pcd);
    check("pc4", PCPlus4D, m_pc4);
`ifdef FETCH_PERF_CNT_EN
    check("fcnt", FetchCount, m_fc);
    check("scnt", StallCount, m_sc);
`endif
  endtask

  task automatic drive_step(
    input bit          a,
    input bit          sf,
    input bit          sd,
    input bit          fl,
    input bit          ps,
    input logic [31:0] tgt
  );
    bit          deliver;
    logic [31:0] di, dp;
    ack_r = a; StallF = sf; StallD = sd;
    FlushD = fl; PCSrcE = ps; PCTargetE = tgt;
    deliver = 0; di = 0; dp = 0;
    if (m_boot) begin
      m_boot = 0;
    end else if (m_drop) begin
      if (a) m_drop = 0;
    end else if (m_hold) begin
      m_sc++;
      if (ps) m_hold = 0;
      else if (!sf && !sd) begin
        deliver = 1; di = m_hw; dp = m_hpc;
        m_hold = 0;
      end
    end else begin
      if (!a) m_sc++;
      if (ps && !a) begin
        m_drop = 1; m_drop_addr = m_pc;
      end else if (a && !ps) begin
        if (sf) begin
          m_hold = 1; m_hw = mem_word(m_pc); m_hpc = m_pc;
        end else begin
          deliver = 1; di = mem_word(m_pc); dp = m_pc;
        end
      end
    end
    if (fl) begin
      m_instr = NOP; m_pcd = 0; m_pc4 = 0;
    end else if (!sd) begin
      if (deliver) begin
        m_instr = di; m_pcd = dp; m_pc4 = dp + 32'd4;
        m_fc++;
      end else begin
        m_instr = NOP; m_pcd = 0; m_pc4 = 0;
      end
    end
    if (ps)           m_pc = tgt;
    else if (deliver) m_pc = m_pc + 32'd4;
  endtask

  task automatic cycle(
    input bit          a,
    input bit          sf,
    input bit          sd,
    input bit          fl,
    input bit          ps,
    input logic [31:0] tgt
  );
    @(negedge clock);
    check_outputs();
    drive_step(a, sf, sd, fl, ps, tgt);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2 reset = 1'b0;
    #1 check("rst_req", {31'b0, imem.ImemReq}, 32'd0);
    model_reset();
    @(negedge clock);
    check_outputs();
    reset = 1'b1;
    drive_step(0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] pick_tgt();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0100;
      1:       return 32'hFFFF_FFFC;
      2:       return 32'h0000_0040;
      default: return {r[31:2], 2'b00};
    endcase
  endfunction

  initial begin
    bit a, sf, sd, fl, ps;
    #1 reset = 1'b0;
    model_reset();
    @(negedge clock);
    check_outputs();
    @(negedge clock);
    check_outputs();
    reset = 1'b1;
    drive_step(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'h0000_0100);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 1, 0, 0);
    cycle(1, 0, 0, 0, 1, 32'hFFFF_FFFC);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        a  = ($urandom_range(0, 9) < 7);
        sf = ($urandom_range(0, 99) < 15);
        sd = sf ? ($urandom_range(0, 3) != 0)
                : ($urandom_range(0, 9) == 0);
        fl = ($urandom_range(0, 99) < 8);
        ps = ($urandom_range(0, 99) < 8);
        cycle(a, sf, sd, fl, ps, pick_tgt());
      end
    end
    @(negedge clock);
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
